// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch sequencer slice: default widths, the HALT
// opcode, the prefetch queue depth and the sequencer state encoding.
// Optional feature macro used by the top level: FETCH_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int FETCH_PC_W        = 10;
   localparam int FETCH_INSTR_W     = 32;
   localparam int FETCH_QUEUE_DEPTH = 2;

   // Value of instr[31:26] that marks a HALT instruction
   localparam logic [5:0] FETCH_HALT_OPCODE = 6'h3F;

   // RUN: fetching, DRAIN: HALT enqueued and fetch stopped, HALTED: drained
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry synchronous FIFO holding {pc, ir} pairs between the instruction
// memory and decode.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   push       write push_data at the tail
//   pop        drop the head entry
//   flush      discard all entries (wins over push/pop)
//   push_data  entry to write
//   head       oldest entry; all zeros when the queue is empty
//   count      number of valid entries (0..2)
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int ENTRY_W = FETCH_PC_W + FETCH_INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] push_data,
   output logic [ENTRY_W-1:0] head,
   output logic [1:0]         count
);

   localparam logic [1:0] FULL_COUNT = 2'(FETCH_QUEUE_DEPTH);

   logic [ENTRY_W-1:0] entry0;
   logic [ENTRY_W-1:0] entry1;
   logic [1:0]         cnt;

   // entry0 is always the head, so a pop shifts entry1 forward. When push and
   // pop coincide the count is unchanged and the new word lands behind
   // whatever remains. Flush only clears the count; stale entries stay
   // invisible because the head is gated by the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry0 <= '0;
         entry1 <= '0;
         cnt    <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) begin
                  entry0 <= push_data;
               end else begin
                  entry1 <= push_data;
               end
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               cnt    <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == FULL_COUNT) begin
                  entry0 <= entry1;
                  entry1 <= push_data;
               end else begin
                  entry0 <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head  = (cnt != 2'd0) ? entry0 : '0;
   assign count = cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Owns the program counter, addresses the combinational instruction memory,
// buffers fetched words in a 2-entry prefetch queue and hands them to decode
// over a valid/ready handshake. Handles redirects (flush + new PC) and stops
// fetching after a HALT opcode until resume.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_pc         instruction memory address (the PC register)
//   imem_ir         instruction word returned for imem_pc, same cycle
//   redirect_valid  one-cycle pulse: flush the queue, fetch from redirect_pc
//   redirect_pc     redirect target
//   fetch_valid     queue head valid
//   fetch_ready     decode accepts the head
//   fetch_ir        head instruction (0 when empty)
//   fetch_pc        PC of head instruction (0 when empty)
//   halted          HALT reached and queue drained
//   resume          leave HALTED and continue after the HALT
//   perf_fetched    (FETCH_PERF_CNT_EN only) saturating count of dequeues
//   perf_stall      (FETCH_PERF_CNT_EN only) saturating count of valid&&!ready
//
// Optional feature macro: FETCH_PERF_CNT_EN adds the two perf counters.
// -----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int               PC_W        = FETCH_PC_W,
   parameter int               INSTR_W     = FETCH_INSTR_W,
   parameter logic [PC_W-1:0]  RESET_PC    = '0,
   parameter logic [5:0]       HALT_OPCODE = FETCH_HALT_OPCODE
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_pc,
   input  logic [INSTR_W-1:0] imem_ir,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               fetch_valid,
   input  logic               fetch_ready,
   output logic [INSTR_W-1:0] fetch_ir,
   output logic [PC_W-1:0]    fetch_pc,
   output logic               halted,
   input  logic               resume
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall
`endif
);

   localparam int         ENTRY_W    = PC_W + INSTR_W;
   localparam logic [1:0] FULL_COUNT = 2'(FETCH_QUEUE_DEPTH);

   fetch_state_e        state;
   fetch_state_e        state_next;
   logic [PC_W-1:0]     pc_reg;
   logic [ENTRY_W-1:0]  q_head;
   logic [1:0]          q_count;
   logic                dequeue;
   logic                enqueue;
   logic                enq_is_halt;
   logic                drained;

   assign dequeue     = fetch_valid && fetch_ready;
   // A full queue may still accept a word when decode frees a slot this edge
   assign enqueue     = (state == RUN) && !redirect_valid
                        && ((q_count < FULL_COUNT) || dequeue);
   assign enq_is_halt = (imem_ir[INSTR_W-1 -: 6] == HALT_OPCODE);
   // True when the queue is empty after this edge
   assign drained     = (q_count == 2'd0) || ((q_count == 2'd1) && dequeue);

   fetch_queue #(
      .ENTRY_W (ENTRY_W)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (enqueue),
      .pop       (dequeue),
      .flush     (redirect_valid),
      .push_data ({pc_reg, imem_ir}),
      .head      (q_head),
      .count     (q_count)
   );

   // PC register: a redirect loads the target, otherwise the PC steps past
   // every enqueued word (including a HALT) and wraps naturally at PC_W bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg <= RESET_PC;
      end else if (redirect_valid) begin
         pc_reg <= redirect_pc;
      end else if (enqueue) begin
         pc_reg <= pc_reg + 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state: redirect overrides everything, including a pending resume
   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         state_next = RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (enqueue && enq_is_halt) begin
                  state_next = DRAIN;
               end
            end
            DRAIN: begin
               if (drained) begin
                  state_next = HALTED;
               end
            end
            HALTED: begin
               if (resume) begin
                  state_next = RUN;
               end
            end
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   assign imem_pc     = pc_reg;
   assign fetch_valid = (q_count != 2'd0);
   assign fetch_pc    = q_head[ENTRY_W-1 -: PC_W];
   assign fetch_ir    = q_head[INSTR_W-1:0];
   assign halted      = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
   // Saturating event counters for delivered words and back-pressure cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (dequeue && (perf_fetched != 32'hFFFF_FFFF)) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (fetch_valid && !fetch_ready && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. Directed scenarios followed by a
// randomized run; a queue-based reference model predicts the delivery stream
// and a separate monitor compares deliveries and per-cycle outputs.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

   typedef struct {
      logic [9:0]  pc;
      logic [31:0] ir;
   } delivery_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  imem_pc;
   logic [31:0] imem_ir;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_ir;
   logic [9:0]  fetch_pc;
   logic        halted;
   logic        resume;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int checks = 0;
   int failures = 0;

   // Memory model: IR = {22'h0, pc}, or a HALT word where marked
   bit halt_at [1024];
   assign imem_ir = halt_at[imem_pc] ? 32'hFC00_0000 : {22'h0, imem_pc};

   fetch_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_pc        (imem_pc),
      .imem_ir        (imem_ir),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_ir       (fetch_ir),
      .fetch_pc       (fetch_pc),
      .halted         (halted),
      .resume         (resume)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the next address to fetch, the words waiting for decode
   // and a mode (0 fetching, 1 waiting for HALT to drain, 2 halted)
   logic [9:0] m_pc;
   delivery_t  m_q[$];
   int         m_mode;
   delivery_t  sb_q[$];

   // Snapshot of what the DUT should show during the current cycle
   bit         snap_ok = 1'b0;
   bit         exp_valid;
   logic [9:0] exp_head;
   logic [9:0] exp_imem_pc;
   bit         exp_halted;

   function automatic logic [31:0] mem_word(input logic [9:0] a);
      return halt_at[a] ? 32'hFC00_0000 : {22'h0, a};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_pc = 10'h000;
      m_q.delete();
      m_mode = 0;
      sb_q.delete();
   endtask

   // Advance the model across one clock edge with the given inputs
   task automatic modelStep(input bit rd, input logic [9:0] rpc,
                            input bit rdy, input bit rsm);
      delivery_t d;
      if ((m_q.size() > 0) && rdy) begin
         sb_q.push_back(m_q.pop_front());
      end
      if (rd) begin
         m_q.delete();
         m_pc   = rpc;
         m_mode = 0;
      end else if (m_mode == 0) begin
         if (m_q.size() < 2) begin
            d.pc = m_pc;
            d.ir = mem_word(m_pc);
            m_q.push_back(d);
            if (halt_at[m_pc]) m_mode = 1;
            m_pc = m_pc + 10'd1;
         end
      end else if (m_mode == 1) begin
         if (m_q.size() == 0) m_mode = 2;
      end else if (rsm) begin
         m_mode = 0;
      end
   endtask

   // Called at a falling edge: record expectations, drive inputs, step model
   task automatic applyStimulus(input bit rd, input logic [9:0] rpc,
                                input bit rdy, input bit rsm);
      exp_valid      = (m_q.size() > 0);
      exp_head       = exp_valid ? m_q[0].pc : 10'h000;
      exp_imem_pc    = m_pc;
      exp_halted     = (m_mode == 2);
      snap_ok        = 1'b1;
      redirect_valid = rd;
      redirect_pc    = rpc;
      fetch_ready    = rdy;
      resume         = rsm;
      modelStep(rd, rpc, rdy, rsm);
      @(negedge clk);
   endtask

   task automatic resetDut();
      snap_ok        = 1'b0;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 10'h000;
      fetch_ready    = 1'b0;
      resume         = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_fetch_valid", fetch_valid, 0);
      checkOutput("reset_fetch_ir", fetch_ir, 0);
      checkOutput("reset_fetch_pc", fetch_pc, 0);
      checkOutput("reset_halted", halted, 0);
      checkOutput("reset_imem_pc", imem_pc, 0);
      rst_n = 1'b1;
   endtask

   // Monitor: compares per-cycle outputs and pops the scoreboard on handshakes
   initial begin : monitor
      delivery_t d;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && snap_ok) begin
            checkOutput("fetch_valid", fetch_valid, exp_valid);
            checkOutput("imem_pc", imem_pc, exp_imem_pc);
            checkOutput("halted", halted, exp_halted);
            if (exp_valid) begin
               checkOutput("head_pc", fetch_pc, exp_head);
            end else begin
               checkOutput("empty_ir", fetch_ir, 0);
               checkOutput("empty_pc", fetch_pc, 0);
            end
            if (fetch_valid && fetch_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL deliver_unexpected actual_pc=0x%0h expected=none",
                           fetch_pc);
               end else begin
                  d = sb_q.pop_front();
                  checkOutput("deliver_pc", fetch_pc, d.pc);
                  checkOutput("deliver_ir", fetch_ir, d.ir);
               end
            end
         end
      end
   end

   initial begin : stimulus
      bit         rd;
      logic [9:0] rpc;
      foreach (halt_at[i]) halt_at[i] = 1'b0;
      resetDut();

      // Streaming: one delivery per cycle, pc 0..7
      repeat (8) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

      // Back-pressure: queue fills, PC holds at 2, then drains with no gap
      resetDut();
      repeat (5) applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
      repeat (6) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

      // Redirect while full
      resetDut();
      repeat (3) applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
      applyStimulus(1'b1, 10'h100, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

      // HALT at word 3, then resume
      halt_at[3] = 1'b1;
      resetDut();
      repeat (10) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
      repeat (6) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
      snap_ok = 1'b0;
      halt_at[3] = 1'b0;

      // PC wrap from 3FF
      resetDut();
      applyStimulus(1'b1, 10'h3FF, 1'b0, 1'b0);
      repeat (6) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

      // Asynchronous reset with a full queue
      repeat (3) applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
      snap_ok = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkOutput("async_reset_valid", fetch_valid, 0);
      checkOutput("async_reset_pc", fetch_pc, 0);
      checkOutput("async_reset_imem_pc", imem_pc, 0);
      resetDut();
      repeat (4) applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);

      // Randomized traffic with a few HALT words in reach
      repeat (4) halt_at[$urandom_range(4, 60)] = 1'b1;
      resetDut();
      for (int n = 0; n < 800; n++) begin
         rd  = ($urandom_range(0, 99) < 3);
         rpc = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1018, 1023))
                                           : 10'($urandom_range(0, 60));
         applyStimulus(rd, rpc, ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 4) == 0));
      end
      snap_ok = 1'b0;
      #3;
      checkOutput("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
